// File: rtl/pipe_pkg.sv
// pipe_pkg: pipeline-wide constants shared by the pipeline registers, forwarding unit and writeback.
package pipe_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int REG_ZERO    = 0;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: selects the writeback value between load data and ALU result.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] wb_data
);
    assign wb_data = mem_to_reg ? mem_data : alu_data;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select plus 2**ADDR_W x DATA_W register file
// with two read ports that bypass the value being written this cycle.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        WBReg,
    input  logic [ADDR_W-1:0] RdReg,
    input  logic [DATA_W-1:0] MemReg,
    input  logic [DATA_W-1:0] ALUReg,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic [DATA_W-1:0] WBData,
    output logic              WBEn
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
    logic [DATA_W-1:0] regs [NREG];
    wb_mux #(.DATA_W(DATA_W)) u_mux (
        .mem_to_reg(WBReg[WB_MEMTOREG]),
        .mem_data  (MemReg),
        .alu_data  (ALUReg),
        .wb_data   (WBData)
    );
    assign WBEn = WBReg[WB_REGWRITE] && (RdReg != ZERO);
    // WBEn already excludes r0, so regs[0] keeps its reset value forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (WBEn) begin
            regs[RdReg] <= WBData;
        end
    end
    assign RsData = (Rs == ZERO) ? '0 : (WBEn && Rs == RdReg) ? WBData : regs[Rs];
    assign RtData = (Rt == ZERO) ? '0 : (WBEn && Rt == RdReg) ? WBData : regs[Rt];
endmodule
